uart_tx_sched: RTL

UART_TX_SCHED -- requirements
Module: uart_tx_sched

---
 rtl/uart_tx_sched.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_sched.sv
// Round-robin byte scheduler feeding a UART transmitter, with its own baud tick generator.
// Optional packet lock (UART_TX_SCHED_LOCK_EN) keeps the grant until a byte flagged req_last.
module uart_tx_sched #(
    parameter int SYSTEM_CLK = 50_000_000,
    parameter int BAUD_RATE  = 9600
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [3:0]  req_valid,
    input  logic [31:0] req_data,
`ifdef UART_TX_SCHED_LOCK_EN
    input  logic [3:0]  req_last,
`endif
    output logic [3:0]  req_ready,
    output logic        tx_en,
    output logic        tx_clk,
    output logic [7:0]  data_in,
    output logic        data_in_valid,
    input  logic        data_in_ready,
    input  logic        tx_clk_en,
    output logic        busy,
    output logic [15:0] frame_cnt
);

    localparam int N  = SYSTEM_CLK / BAUD_RATE;
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] CNT_MAX = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        WAIT_LO = 2'd2,
        WAIT_HI = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] baud_cnt;
    logic [1:0]    grant;
    logic [1:0]    last;
    logic [1:0]    arb_idx;
    logic [1:0]    cand;
    logic          found;
    logic          any_valid;
    logic          accept;
    logic          frame_done;
`ifdef UART_TX_SCHED_LOCK_EN
    logic          lock_hold;
`endif

    assign tx_en      = enable;
    assign busy       = (state != IDLE);
    assign any_valid  = |req_valid;
    assign accept     = enable && (state == SEND) && data_in_ready;
    assign frame_done = enable && (state == WAIT_HI) && data_in_ready;

    // Baud tick: count only while the transmitter asks for it, one-clk pulse at wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt <= '0;
            tx_clk   <= 1'b0;
        end else if (!enable || !tx_clk_en) begin
            baud_cnt <= '0;
            tx_clk   <= 1'b0;
        end else begin
            tx_clk   <= (baud_cnt == CNT_MAX);
            baud_cnt <= (baud_cnt == CNT_MAX) ? '0 : baud_cnt + CW'(1);
        end
    end

    // Search upward from the requester after the last one served.
    always_comb begin
        arb_idx = last;
        cand    = last;
        found   = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand = last + 2'(k);
            if (!found && req_valid[cand]) begin
                arb_idx = cand;
                found   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (any_valid) state_nxt = SEND;
                SEND:    if (data_in_ready) state_nxt = WAIT_LO;
                WAIT_LO: if (!data_in_ready) state_nxt = WAIT_HI;
                WAIT_HI: begin
                    if (data_in_ready) begin
`ifdef UART_TX_SCHED_LOCK_EN
                        state_nxt = lock_hold ? SEND : IDLE;
`else
                        state_nxt = IDLE;
`endif
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready     = '0;
        data_in_valid = 1'b0;
        data_in       = '0;
        if (state == SEND) begin
            data_in_valid = 1'b1;
            data_in       = req_data[{grant, 3'b000} +: 8];
            if (accept) begin
                req_ready[grant] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant     <= 2'd0;
            last      <= 2'd3;
            frame_cnt <= 16'd0;
        end else begin
            if (enable && (state == IDLE) && any_valid) begin
                grant <= arb_idx;
            end
            if (accept) begin
                last <= grant;
            end
            if (frame_done) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

`ifdef UART_TX_SCHED_LOCK_EN
    // Lock follows the end-of-packet flag of the byte actually accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_hold <= 1'b0;
        end else if (!enable) begin
            lock_hold <= 1'b0;
        end else if (accept) begin
            lock_hold <= !req_last[grant];
        end
    end
`endif

endmodule
